// File: rtl/param_locker.sv
// Digit-entry code lock with retry limit and timed lockout.
// Optional macro LOCKER_CODE_CHANGE_EN adds the PROGRAM state and a writable code register.
module param_locker #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             submit,
    input  logic [DIGIT_W-1:0]               digit_in,
    input  logic                             clear,
    input  logic                             relock,
    input  logic                             set_code,
    output logic                             unlocked,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts_left,
    output logic                             bad_code,
    output logic [$clog2(DIGITS+1)-1:0]      digit_cnt
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int AW     = $clog2(MAX_TRIES + 1);
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int TW     = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        PROGRAM  = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CODE_W-1:0]   entry_reg, entry_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [AW-1:0]       att_reg, att_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic                bad_reg, bad_next;
    logic                submit_prev_reg;
    logic                unlocked_reg;
    logic                locked_reg;
    logic [CODE_W-1:0]   code_cur;
    logic [CODE_W-1:0]   entry_shift;
    logic                accept;
    logic                last_digit;

    assign accept      = submit & ~submit_prev_reg;
    // Oldest digit ends up in the most significant position.
    assign entry_shift = CODE_W'({entry_reg, digit_in});
    assign last_digit  = (cnt_reg == CW'(DIGITS - 1));

`ifdef LOCKER_CODE_CHANGE_EN
    logic [CODE_W-1:0] code_reg, code_next;
    assign code_cur = code_reg;
`else
    logic unused_set_code;
    assign unused_set_code = set_code;
    assign code_cur        = DEFAULT_CODE;
`endif

    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        cnt_next   = cnt_reg;
        att_next   = att_reg;
        timer_next = timer_reg;
        bad_next   = 1'b0;
`ifdef LOCKER_CODE_CHANGE_EN
        code_next  = code_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    cnt_next = '0;
                end else if (accept) begin
                    entry_next = entry_shift;
                    if (last_digit) begin
                        cnt_next = '0;
                        if (entry_shift == code_cur) begin
                            state_next = UNLOCKED;
                            att_next   = AW'(MAX_TRIES);
                        end else begin
                            bad_next = 1'b1;
                            if (att_reg > AW'(1)) begin
                                att_next = att_reg - AW'(1);
                            end else begin
                                att_next   = '0;
                                state_next = LOCKOUT;
                                timer_next = TW'(LOCK_CYCLES);
                            end
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    state_next = IDLE;
                    cnt_next   = '0;
`ifdef LOCKER_CODE_CHANGE_EN
                end else if (set_code) begin
                    state_next = PROGRAM;
                    cnt_next   = '0;
`endif
                end
            end
`ifdef LOCKER_CODE_CHANGE_EN
            PROGRAM: begin
                if (relock) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (clear) begin
                    cnt_next = '0;
                end else if (accept) begin
                    entry_next = entry_shift;
                    if (last_digit) begin
                        code_next  = entry_shift;
                        state_next = UNLOCKED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
`endif
            LOCKOUT: begin
                // Leaving on the edge where the timer would hit zero keeps locked high for exactly LOCK_CYCLES cycles.
                if (timer_reg <= TW'(1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    att_next   = AW'(MAX_TRIES);
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            entry_reg       <= '0;
            cnt_reg         <= '0;
            att_reg         <= AW'(MAX_TRIES);
            timer_reg       <= '0;
            bad_reg         <= 1'b0;
            submit_prev_reg <= 1'b0;
            unlocked_reg    <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            entry_reg       <= entry_next;
            cnt_reg         <= cnt_next;
            att_reg         <= att_next;
            timer_reg       <= timer_next;
            bad_reg         <= bad_next;
            submit_prev_reg <= submit;
            unlocked_reg    <= (state_next == UNLOCKED) || (state_next == PROGRAM);
            locked_reg      <= (state_next == LOCKOUT);
        end
    end

`ifdef LOCKER_CODE_CHANGE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            code_reg <= DEFAULT_CODE;
        end else begin
            code_reg <= code_next;
        end
    end
`endif

    assign unlocked      = unlocked_reg;
    assign locked        = locked_reg;
    assign attempts_left = att_reg;
    assign bad_code      = bad_reg;
    assign digit_cnt     = cnt_reg;

endmodule

// File: tb/tb_param_locker.sv
// Bench for param_locker: vector table on a default instance plus hand sequences,
// and a second 6x8-bit, 5-try instance.
module tb_param_locker;
    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       submit, clear, relock, set_code;
    logic [7:0] digit;

    logic       unl_a, lck_a, bad_a;
    logic [1:0] att_a;
    logic [2:0] cnt_a;
    logic       unl_b, lck_b, bad_b;
    logic [2:0] att_b;
    logic [2:0] cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_locker dut_a (
        .clk(clk), .reset(reset_a), .submit(submit), .digit_in(digit[3:0]),
        .clear(clear), .relock(relock), .set_code(set_code),
        .unlocked(unl_a), .locked(lck_a), .attempts_left(att_a),
        .bad_code(bad_a), .digit_cnt(cnt_a)
    );

    param_locker #(
        .DIGITS(6), .DIGIT_W(8), .MAX_TRIES(5), .LOCK_CYCLES(16),
        .DEFAULT_CODE(48'h0A0B0C0D0E0F)
    ) dut_b (
        .clk(clk), .reset(reset_b), .submit(submit), .digit_in(digit),
        .clear(clear), .relock(relock), .set_code(set_code),
        .unlocked(unl_b), .locked(lck_b), .attempts_left(att_b),
        .bad_code(bad_b), .digit_cnt(cnt_b)
    );

    typedef struct {
        logic       sub;
        logic [3:0] d;
        logic       clr;
        logic       rl;
        logic       sc;
        logic       e_unl;
        logic       e_lck;
        logic [1:0] e_att;
        logic       e_bad;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [7:0] d, input logic c,
                       input logic r, input logic sc);
        submit = s; digit = d; clear = c; relock = r; set_code = sc;
        @(posedge clk);
        #1;
    endtask

    // Each digit: one idle cycle then a submit edge; returns right after the final digit's edge.
    task automatic enter(input logic [47:0] code, input int n, input int w);
        logic [47:0] mask;
        mask = (48'd1 << w) - 48'd1;
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 8'((code >> (w * (n - 1 - k))) & mask), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic add(input logic s, input logic [3:0] d, input logic c, input logic r,
                       input logic sc, input logic unl, input logic lck, input logic [1:0] att,
                       input logic bad, input logic [2:0] cnt);
        vec_t v;
        v.sub = s; v.d = d; v.clr = c; v.rl = r; v.sc = sc;
        v.e_unl = unl; v.e_lck = lck; v.e_att = att; v.e_bad = bad; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Four-digit entry in IDLE: three counted digits, then the final digit outcome and its release cycle.
    task automatic add_code(input logic [15:0] code, input logic [1:0] att0, input logic f_unl,
                            input logic f_lck, input logic [1:0] f_att, input logic f_bad);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                add(1'b1, code[15-4*k -: 4], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, att0, 1'b0, 3'(k + 1));
                add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, att0, 1'b0, 3'(k + 1));
            end else begin
                add(1'b1, code[3:0], 1'b0, 1'b0, 1'b0, f_unl, f_lck, f_att, f_bad, 3'd0);
                add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, f_unl, f_lck, f_att, 1'b0, 3'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        submit = 1'b0; digit = 8'h00; clear = 1'b0; relock = 1'b0; set_code = 1'b0;

        // ---------------- reset state with busy inputs ----------------
        cyc(1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
        chk("rst_a.unlocked", unl_a, 0);
        chk("rst_a.locked", lck_a, 0);
        chk("rst_a.attempts", att_a, 3);
        chk("rst_a.bad", bad_a, 0);
        chk("rst_a.cnt", cnt_a, 0);
        chk("rst_b.attempts", att_b, 5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_a = 1'b1;

        // ---------------- vector table ----------------
        add_code(16'h1234, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0);
        add(1'b1, 4'h9, 0, 0, 0, 1, 0, 2'd3, 0, 3'd0);   // submit ignored while unlocked
        add(1'b0, 4'h0, 0, 0, 0, 1, 0, 2'd3, 0, 3'd0);
        add(1'b0, 4'h0, 0, 1, 0, 0, 0, 2'd3, 0, 3'd0);   // relock
        add(1'b1, 4'h1, 0, 0, 0, 0, 0, 2'd3, 0, 3'd1);
        add(1'b0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0, 3'd1);
        add(1'b1, 4'h2, 0, 0, 0, 0, 0, 2'd3, 0, 3'd2);
        add(1'b0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0, 3'd2);
        add(1'b0, 4'h0, 1, 0, 0, 0, 0, 2'd3, 0, 3'd0);   // clear
        add(1'b1, 4'h7, 1, 0, 0, 0, 0, 2'd3, 0, 3'd0);   // clear beats a digit
        add(1'b0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0, 3'd0);
        add_code(16'h1234, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0);
        add(1'b0, 4'h0, 0, 1, 0, 0, 0, 2'd3, 0, 3'd0);
        for (int i = 0; i < 5; i++) add(1'b1, 4'h1, 0, 0, 0, 0, 0, 2'd3, 0, 3'd1);  // held submit
        add(1'b0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0, 3'd1);
        add(1'b0, 4'h0, 1, 0, 0, 0, 0, 2'd3, 0, 3'd0);
        add_code(16'h0000, 2'd3, 1'b0, 1'b0, 2'd2, 1'b1);
        add_code(16'h9999, 2'd2, 1'b0, 1'b0, 2'd1, 1'b1);
        add_code(16'h8888, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1);
        // Lockout ticks 3..16 with every control input poked.
        for (int i = 0; i < 14; i++)
            add((i % 2) == 0, 4'h1, i == 4, i == 6, i == 8, 0, 1, 2'd0, 0, 3'd0);
        add(1'b1, 4'h1, 0, 0, 0, 0, 0, 2'd3, 0, 3'd0);   // back to IDLE, submit edge swallowed
        add(1'b1, 4'h1, 0, 0, 0, 0, 0, 2'd3, 0, 3'd0);   // still held: no count
        add(1'b0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0, 3'd0);
        add_code(16'h1234, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0);
        add(1'b0, 4'h0, 0, 1, 0, 0, 0, 2'd3, 0, 3'd0);

        foreach (vecs[i]) begin
            cyc(vecs[i].sub, {4'h0, vecs[i].d}, vecs[i].clr, vecs[i].rl, vecs[i].sc);
            $display("[TB] vec %0d sub=%0d d=%0h clr=%0d rl=%0d sc=%0d -> unl=%0d lck=%0d att=%0d bad=%0d cnt=%0d",
                     i, vecs[i].sub, vecs[i].d, vecs[i].clr, vecs[i].rl, vecs[i].sc,
                     unl_a, lck_a, att_a, bad_a, cnt_a);
            chk($sformatf("vec%0d.unlocked", i), unl_a, vecs[i].e_unl);
            chk($sformatf("vec%0d.locked", i), lck_a, vecs[i].e_lck);
            chk($sformatf("vec%0d.attempts", i), att_a, vecs[i].e_att);
            chk($sformatf("vec%0d.bad", i), bad_a, vecs[i].e_bad);
            chk($sformatf("vec%0d.cnt", i), cnt_a, vecs[i].e_cnt);
        end

        // ---------------- reset mid-entry and mid-lockout ----------------
        $display("[TB] reset mid-entry / mid-lockout");
        enter(48'h0000, 4, 4);
        chk("rst_seq.bad", bad_a, 1);
        chk("rst_seq.att2", att_a, 2);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
        end
        chk("rst_seq.cnt3", cnt_a, 3);
        reset_a = 1'b0;
        cyc(1'b1, 8'h05, 1'b1, 1'b1, 1'b1);
        chk("rst_entry.cnt", cnt_a, 0);
        chk("rst_entry.att", att_a, 3);
        chk("rst_entry.locked", lck_a, 0);
        chk("rst_entry.unlocked", unl_a, 0);
        reset_a = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        enter(48'h0000, 4, 4);
        enter(48'h0000, 4, 4);
        enter(48'h0000, 4, 4);
        chk("rst_lock.locked_in", lck_a, 1);
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_lock.still_locked", lck_a, 1);
        reset_a = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_lock.locked", lck_a, 0);
        chk("rst_lock.att", att_a, 3);
        chk("rst_lock.cnt", cnt_a, 0);
        reset_a = 1'b1;
        enter(48'h1234, 4, 4);
        chk("rst_lock.unlock_after", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rst_lock.relock", unl_a, 0);

`ifdef LOCKER_CODE_CHANGE_EN
        // ---------------- code programming ----------------
        $display("[TB] code change sequence");
        enter(48'h1234, 4, 4);
        chk("prog.unlock", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("prog.enter_unl", unl_a, 1);
        chk("prog.enter_cnt", cnt_a, 0);
        enter(48'h5678, 4, 4);
        chk("prog.done_unl", unl_a, 1);
        chk("prog.done_cnt", cnt_a, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("prog.relock", unl_a, 0);
        enter(48'h1234, 4, 4);
        chk("prog.old_bad", bad_a, 1);
        chk("prog.old_att", att_a, 2);
        enter(48'h5678, 4, 4);
        chk("prog.new_unl", unl_a, 1);
        chk("prog.new_att", att_a, 3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        reset_a = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_a = 1'b1;
        enter(48'h1234, 4, 4);
        chk("prog.reset_default", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        chk("prog.partial_cnt", cnt_a, 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("prog.abort_unl", unl_a, 0);
        chk("prog.abort_cnt", cnt_a, 0);
        enter(48'h1234, 4, 4);
        chk("prog.code_kept", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("prog.relock_wins", unl_a, 0);
`else
        // ---------------- set_code has no effect ----------------
        $display("[TB] set_code ignored");
        enter(48'h1234, 4, 4);
        chk("nosc.unlock", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        chk("nosc.cnt", cnt_a, 0);
        chk("nosc.unl", unl_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("nosc.relock", unl_a, 0);
`endif

        // ---------------- 6 x 8-bit, 5 tries ----------------
        $display("[TB] wide instance");
        reset_a = 1'b0;
        reset_b = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("b.att_init", att_b, 5);
        enter(48'h0A0B0C0D0E0F, 6, 8);
        chk("b.unlock", unl_b, 1);
        chk("b.att", att_b, 5);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("b.relock", unl_b, 0);
        for (int t = 0; t < 5; t++) begin
            enter(48'h111111111111, 6, 8);
            $display("[TB] b wrong code %0d -> att=%0d bad=%0d lck=%0d", t, att_b, bad_b, lck_b);
            chk($sformatf("b.wrong%0d.bad", t), bad_b, 1);
            chk($sformatf("b.wrong%0d.att", t), att_b, 4 - t);
            chk($sformatf("b.wrong%0d.locked", t), lck_b, (t == 4) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/param_locker.md
PARAM_LOCKER -- requirements
Module: param_locker

Interface
REQ-001 Parameter DIGITS, default 4, number of digits per code (>=1).
REQ-002 Parameter DIGIT_W, default 4, bits per digit.
REQ-003 Parameter MAX_TRIES, default 3, wrong codes allowed before lockout (>=1).
REQ-004 Parameter LOCK_CYCLES, default 16, lockout duration in clk cycles (>=1).
REQ-005 Parameter DEFAULT_CODE, default 16'h1234, DIGITS*DIGIT_W bits; first-entered digit is the MS digit.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 submit  input  1  digit strobe.
REQ-009 digit_in  input  DIGIT_W  digit value, sampled with submit.
REQ-010 clear  input  1  abandon the partial entry.
REQ-011 relock  input  1  return from UNLOCKED to IDLE.
REQ-012 set_code  input  1  request code programming while unlocked.
REQ-013 unlocked  output  1  high in UNLOCKED and PROGRAM.
REQ-014 locked  output  1  high in LOCKOUT.
REQ-015 attempts_left  output  $clog2(MAX_TRIES+1)  remaining tries.
REQ-016 bad_code  output  1  one-cycle pulse on a wrong complete code.
REQ-017 digit_cnt  output  $clog2(DIGITS+1)  digits accepted in the current entry.

Function
REQ-018 A digit SHALL be accepted only on a submit rising edge (submit=1 in this cycle, 0 in the previous cycle); holding submit high SHALL count once.
REQ-019 States SHALL be IDLE, UNLOCKED, PROGRAM and LOCKOUT; all outputs SHALL be registered.
REQ-020 In IDLE, each accepted digit SHALL shift into the entry register and increment digit_cnt.
REQ-021 The code SHALL be compared only after DIGITS digits; the block SHALL NOT reject early on the first wrong digit.
REQ-022 Match: at the edge that accepts the final digit, go to UNLOCKED, set attempts_left=MAX_TRIES and digit_cnt=0.
REQ-023 Mismatch with attempts_left>1: decrement attempts_left, pulse bad_code, set digit_cnt=0, stay in IDLE.
REQ-024 Mismatch with attempts_left=1: set attempts_left=0, pulse bad_code, go to LOCKOUT and load the timer with LOCK_CYCLES.
REQ-025 LOCKOUT SHALL ignore submit, clear, relock and set_code, and SHALL decrement the timer each cycle.
REQ-026 When the timer reaches 0, go to IDLE with attempts_left=MAX_TRIES.
REQ-027 clear in IDLE SHALL zero digit_cnt without consuming an attempt; if clear and an accepted digit occur in the same cycle, clear wins.
REQ-028 UNLOCKED SHALL ignore submit; relock SHALL go to IDLE; relock SHALL win over a simultaneous set_code.
REQ-029 PROGRAM SHALL accept DIGITS digits, write them to the code register at the final digit, and return to UNLOCKED; relock aborts to IDLE with the code unchanged.
REQ-030 The submit edge detector SHALL track submit in every state, so a held submit never counts after a state change.

Reset
REQ-031 While reset=0 at a clk edge: state=IDLE, unlocked=0, locked=0, bad_code=0, digit_cnt=0, attempts_left=MAX_TRIES, timer=0, previous-submit=0, code register=DEFAULT_CODE.
REQ-032 Reset SHALL override every input in any state, including mid-entry, PROGRAM and LOCKOUT.

Configuration
REQ-033 Macro LOCKER_CODE_CHANGE_EN: when defined, PROGRAM state and the writable code register SHALL be present.
REQ-034 When LOCKER_CODE_CHANGE_EN is undefined, set_code SHALL be ignored, PROGRAM SHALL be unreachable, and the code SHALL be the constant DEFAULT_CODE.

Verification
REQ-035 Defaults; reset, then digits 1,2,3,4 -> unlocked=1 at the 4th-digit edge, attempts_left=3, bad_code never pulses.
REQ-036 Codes 0000, 9999, 8888 -> attempts_left 2, then 1, then 0; three bad_code pulses; locked=1 for 16 cycles; then IDLE with attempts_left=3.
REQ-037 Digits 1,2 then clear then 1,2,3,4 -> unlocked=1, attempts_left stays 3; submit held high for 5 cycles -> digit_cnt=1.
REQ-038 With LOCKER_CODE_CHANGE_EN: unlock, set_code, enter 5,6,7,8, relock; 1,2,3,4 -> bad_code pulse; 5,6,7,8 -> unlocked; reset then 1,2,3,4 -> unlocked.
REQ-039 reset=0 for one cycle after 3 digits, and again mid-LOCKOUT -> digit_cnt=0, locked=0, attempts_left=3, state IDLE.
REQ-040 DIGITS=6, DIGIT_W=8, MAX_TRIES=5 -> 6-digit match unlocks; 5 wrong codes -> lockout.
